// File: rtl/bcd_req_arbiter_if.sv
// Request/grant bundle for the ten-way BCD request arbiter.
// The slave side is the arbiter; the master side is the request source and grant consumer.
interface bcd_req_arbiter_if;
  logic [9:0] req;
  logic       done;
  logic [9:0] gnt;
  logic [3:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/bcd_req_arbiter.sv
// Ten-requester arbiter with a one-hot grant and a BCD index, round-robin or fixed priority.
// A grant is held until done, a withdrawal of the request, or HOLD_MAX cycles elapse.
module bcd_req_arbiter #(
  parameter int RR       = 1,
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
  input  logic               clk,
  input  logic               rst,
  bcd_req_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t          state, state_n;
  logic [9:0]      gnt_p0, gnt_n;
  logic [3:0]      gnt_id_p0, gnt_id_n;
  logic            vld_p0, vld_n;
  logic            timeout_p0, timeout_n;
  logic [CW-1:0]   hold_cnt, hold_cnt_n;
  logic [3:0]      last_id, last_id_n;
  logic [3:0]      win;

  // Round-robin scans upward from the index after the previous winner, wrapping at 9.
  function automatic logic [3:0] pick(input logic [9:0] r, input logic [3:0] last);
    logic [3:0] w;
    logic [3:0] idx;
    logic       found;
    int         t;
    w     = 4'd0;
    found = 1'b0;
    if (RR != 0) begin
      for (int k = 1; k <= 10; k++) begin
        t   = (int'(last) + k) % 10;
        idx = 4'(t);
        if (!found && r[idx]) begin
          w     = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 9; k >= 0; k--) begin
        idx = 4'(k);
        if (r[idx]) w = idx;
      end
    end
    return w;
  endfunction

  always_comb begin
    state_n    = state;
    gnt_n      = gnt_p0;
    gnt_id_n   = gnt_id_p0;
    vld_n      = vld_p0;
    timeout_n  = 1'b0;
    hold_cnt_n = hold_cnt;
    last_id_n  = last_id;
    win        = pick(bus.req, last_id);
    case (state)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_n      = 10'd1 << win;
          gnt_id_n   = win;
          vld_n      = 1'b1;
          hold_cnt_n = '0;
          last_id_n  = win;
          state_n    = S_GRANT;
        end
      end
      S_GRANT: begin
        // done outranks withdrawal, which outranks expiry; only expiry flags timeout.
        if (bus.done || !(|(bus.req & gnt_p0))) begin
          gnt_n    = '0;
          gnt_id_n = 4'd0;
          vld_n    = 1'b0;
          state_n  = S_RELEASE;
        end else if (hold_cnt == CW'(HOLD_MAX - 1)) begin
          gnt_n     = '0;
          gnt_id_n  = 4'd0;
          vld_n     = 1'b0;
          timeout_n = 1'b1;
          state_n   = S_RELEASE;
        end else begin
          hold_cnt_n = hold_cnt + CW'(1);
        end
      end
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt_p0     <= '0;
      gnt_id_p0  <= 4'd0;
      vld_p0     <= 1'b0;
      timeout_p0 <= 1'b0;
      hold_cnt   <= '0;
      last_id    <= 4'd9;
    end else begin
      state      <= state_n;
      gnt_p0     <= gnt_n;
      gnt_id_p0  <= gnt_id_n;
      vld_p0     <= vld_n;
      timeout_p0 <= timeout_n;
      hold_cnt   <= hold_cnt_n;
      last_id    <= last_id_n;
    end
  end

  assign bus.gnt       = gnt_p0;
  assign bus.gnt_id    = gnt_id_p0;
  assign bus.gnt_valid = vld_p0;
  assign bus.timeout   = timeout_p0;

endmodule

// File: tb/tb_bcd_req_arbiter.sv
// Directed bench for bcd_req_arbiter: three instances cover round-robin, fixed priority
// and a short hold limit; expected grants are hand-derived constants.
module tb_bcd_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_req_arbiter_if ia ();  // RR=1, HOLD_MAX=8
  bcd_req_arbiter_if ib ();  // RR=0, HOLD_MAX=8
  bcd_req_arbiter_if ic ();  // RR=1, HOLD_MAX=4

  bcd_req_arbiter #(.RR(1), .HOLD_MAX(8), .CW(8)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  bcd_req_arbiter #(.RR(0), .HOLD_MAX(8), .CW(8)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  bcd_req_arbiter #(.RR(1), .HOLD_MAX(4), .CW(8)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] g, input logic [3:0] id,
                     input logic v, input logic to,
                     input logic [3:0] eid, input logic ev, input logic eto);
    logic [9:0] eg;
    logic [3:0] eidm;
    eg   = ev ? (10'd1 << eid) : 10'd0;
    eidm = ev ? eid : 4'd0;
    checks++;
    assert ({g, id, v, to} === {eg, eidm, ev, eto})
    else begin
      errors++;
      $error("FAIL %s: observed gnt=%h id=%h valid=%b timeout=%b, expected gnt=%h id=%h valid=%b timeout=%b",
             tag, g, id, v, to, eg, eidm, ev, eto);
    end
  endtask

  task automatic ca(input string tag, input logic [3:0] eid, input logic ev, input logic eto);
    chk(tag, ia.gnt, ia.gnt_id, ia.gnt_valid, ia.timeout, eid, ev, eto);
  endtask
  task automatic cb(input string tag, input logic [3:0] eid, input logic ev, input logic eto);
    chk(tag, ib.gnt, ib.gnt_id, ib.gnt_valid, ib.timeout, eid, ev, eto);
  endtask
  task automatic cc(input string tag, input logic [3:0] eid, input logic ev, input logic eto);
    chk(tag, ic.gnt, ic.gnt_id, ic.gnt_valid, ic.timeout, eid, ev, eto);
  endtask

  task automatic do_reset();
    ia.req = '0; ib.req = '0; ic.req = '0;
    ia.done = 1'b0; ib.done = 1'b0; ic.done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq = '{4'd0, 4'd4, 4'd9, 4'd0, 4'd4};

    do_reset();
    ca("reset_a", 4'd0, 1'b0, 1'b0);
    cb("reset_b", 4'd0, 1'b0, 1'b0);
    cc("reset_c", 4'd0, 1'b0, 1'b0);

    // T1: single request, done during the third grant cycle
    ia.req = 10'h008;
    tick(); ca("t1_grant_c1", 4'd3, 1'b1, 1'b0);
    tick(); ca("t1_grant_c2", 4'd3, 1'b1, 1'b0);
    tick(); ca("t1_grant_c3", 4'd3, 1'b1, 1'b0);
    ia.done = 1'b1;
    tick(); ca("t1_release", 4'd0, 1'b0, 1'b0);
    ia.done = 1'b0;
    tick(); ca("t1_idle", 4'd0, 1'b0, 1'b0);
    tick(); ca("t1_regrant", 4'd3, 1'b1, 1'b0);
    ia.req = '0;
    tick(); ca("t1_withdraw", 4'd0, 1'b0, 1'b0);
    tick();

    // T2 / T3: requesters 0, 4, 9 with done after one grant cycle
    do_reset();
    ia.req = 10'h211;
    ib.req = 10'h211;
    for (int i = 0; i < 5; i++) begin
      tick();
      ca($sformatf("t2_grant%0d", i), rr_seq[i], 1'b1, 1'b0);
      if (i < 3) cb($sformatf("t3_grant%0d", i), 4'd0, 1'b1, 1'b0);
      ia.done = 1'b1;
      ib.done = (i < 3);
      tick();
      ca($sformatf("t2_gap%0d_a", i), 4'd0, 1'b0, 1'b0);
      if (i < 3) cb($sformatf("t3_gap%0d_a", i), 4'd0, 1'b0, 1'b0);
      ia.done = 1'b0;
      ib.done = 1'b0;
      tick();
      ca($sformatf("t2_gap%0d_b", i), 4'd0, 1'b0, 1'b0);
      if (i < 3) cb($sformatf("t3_gap%0d_b", i), 4'd0, 1'b0, 1'b0);
      if (i == 2) ib.req = 10'h210;
    end
    cb("t3_after_drop", 4'd4, 1'b1, 1'b0);
    ia.req = '0;
    ib.req = '0;
    tick(); tick(); tick();

    // T4: hold limit of 4 cycles
    ic.req = 10'h080;
    tick(); cc("t4_hold0", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_hold1", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_hold2", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_hold3", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_expire", 4'd0, 1'b0, 1'b1);
    tick(); cc("t4_pulse_end", 4'd0, 1'b0, 1'b0);
    tick(); cc("t4_regrant", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_r_hold1", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_r_hold2", 4'd7, 1'b1, 1'b0);
    tick(); cc("t4_r_hold3", 4'd7, 1'b1, 1'b0);
    ic.done = 1'b1;
    tick(); cc("t4_done_beats_timeout", 4'd0, 1'b0, 1'b0);
    ic.done = 1'b0;
    ic.req = '0;
    tick(); tick();

    // T5: withdrawal mid-grant, then done while idle
    ia.req = 10'h020;
    tick(); ca("t5_grant", 4'd5, 1'b1, 1'b0);
    tick(); ca("t5_hold", 4'd5, 1'b1, 1'b0);
    ia.req = '0;
    tick(); ca("t5_withdraw", 4'd0, 1'b0, 1'b0);
    tick(); ca("t5_idle", 4'd0, 1'b0, 1'b0);
    ia.done = 1'b1;
    tick(); ca("t5_done_idle", 4'd0, 1'b0, 1'b0);
    ia.done = 1'b0;
    ia.req = 10'h020;
    tick(); ca("t5_regrant", 4'd5, 1'b1, 1'b0);
    ia.req = '0;
    tick(); tick(); tick();

    // T6: reset during a grant clears outputs and fairness history
    ia.req = 10'h040;
    tick(); ca("t6_grant6", 4'd6, 1'b1, 1'b0);
    ia.req = 10'h044;
    ib.req = 10'h044;
    rst = 1'b1;
    tick(); ca("t6_reset_a", 4'd0, 1'b0, 1'b0);
    cb("t6_reset_b", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); ca("t6_post_rr", 4'd2, 1'b1, 1'b0);
    cb("t6_post_fp", 4'd2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
